// File: rtl/frame_bank_arbiter_if.sv
// Frame bank arbiter bus: writer stream, reader slice port, frame RAM port and status.
// master = surrounding system (writer, reader, RAM model); slave = frame_bank_arbiter.
interface frame_bank_arbiter_if #(
    parameter int RAM_ADDR_WIDTH = 32,
    parameter int RAM_DATA_WIDTH = 16,
    parameter int OFS_WIDTH      = 12
);
    // writer side
    logic                      wr_req;
    logic [OFS_WIDTH-1:0]      wr_ofs;
    logic [RAM_DATA_WIDTH-1:0] wr_data;
    logic                      wr_frame_done;
    // reader side
    logic                      rd_req;
    logic [OFS_WIDTH-1:0]      rd_ofs;
    logic                      rd_gnt;
    logic                      rd_valid;
    logic [RAM_DATA_WIDTH-1:0] rd_data;
    logic                      rd_frame_next;
    // frame RAM port
    logic [RAM_ADDR_WIDTH-1:0] ram_addr;
    logic [RAM_DATA_WIDTH-1:0] ram_wdata;
    logic                      ram_we;
    logic [RAM_DATA_WIDTH-1:0] ram_rdata;
    // status
    logic                      stream_ready;
    logic                      ofs_err;

    modport master (
        output wr_req, wr_ofs, wr_data, wr_frame_done,
        output rd_req, rd_ofs, rd_frame_next, ram_rdata,
        input  rd_gnt, rd_valid, rd_data,
        input  ram_addr, ram_wdata, ram_we,
        input  stream_ready, ofs_err
    );

    modport slave (
        input  wr_req, wr_ofs, wr_data, wr_frame_done,
        input  rd_req, rd_ofs, rd_frame_next, ram_rdata,
        output rd_gnt, rd_valid, rd_data,
        output ram_addr, ram_wdata, ram_we,
        output stream_ready, ofs_err
    );
endinterface

// File: rtl/frame_bank_arbiter.sv
// Triple-buffer bank scheduler and single-port frame RAM arbiter.
// The writer fills bank W, completed frames are published to bank R, and the
// reader swaps the newest frame into bank D at its frame boundaries.
// The writer always wins the RAM port so the pixel stream never stalls.
// Optional macro FB_STATS_EN adds saturating drop_cnt / repeat_cnt outputs.
module frame_bank_arbiter #(
    parameter int RAM_ADDR_WIDTH = 32,
    parameter int RAM_DATA_WIDTH = 16,
    parameter int FRAME_WORDS    = 3840,
    parameter int OFS_WIDTH      = 12
) (
    input  logic                 clk,
    input  logic                 rst,
    frame_bank_arbiter_if.slave  bus
`ifdef FB_STATS_EN
    ,
    output logic [15:0]          drop_cnt,
    output logic [15:0]          repeat_cnt
`endif
);

    typedef logic [1:0] bank_t;

    // One extra bit so FRAME_WORDS == 2**OFS_WIDTH still fits.
    localparam logic [OFS_WIDTH:0] FRAME_LIMIT = (OFS_WIDTH + 1)'(FRAME_WORDS);

    bank_t                     w_bank;
    bank_t                     r_bank;
    bank_t                     d_bank;
    logic                      rdy_valid;
    logic                      stream_ready_q;
    logic                      ofs_err_q;
    logic                      rd_valid_q;

    logic                      wr_bad;
    logic                      rd_bad;
    logic                      err_hit;
    logic                      gnt;
    logic                      we;
    logic [RAM_ADDR_WIDTH-1:0] addr;

    // Absolute RAM address of an offset inside a bank; no wrap is applied.
    function automatic logic [RAM_ADDR_WIDTH-1:0] bank_addr(bank_t b, logic [OFS_WIDTH-1:0] ofs);
        return RAM_ADDR_WIDTH'(b) * RAM_ADDR_WIDTH'(FRAME_WORDS) + RAM_ADDR_WIDTH'(ofs);
    endfunction

    assign wr_bad = {1'b0, bus.wr_ofs} >= FRAME_LIMIT;
    assign rd_bad = {1'b0, bus.rd_ofs} >= FRAME_LIMIT;

    // Port decode: writer first, then reader; out-of-range offsets leave the port idle.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        addr    = '0;
        we      = 1'b0;
        gnt     = 1'b0;
        err_hit = 1'b0;
        if (!rst) begin
            if (bus.wr_req) begin
                if (wr_bad) begin
                    err_hit = 1'b1;
                end else begin
                    addr = bank_addr(w_bank, bus.wr_ofs);
                    we   = 1'b1;
                end
            end else if (bus.rd_req) begin
                if (rd_bad) begin
                    err_hit = 1'b1;
                end else begin
                    addr = bank_addr(d_bank, bus.rd_ofs);
                    gnt  = 1'b1;
                end
            end
        end
    end

    // Bank rotation on frame events; swaps are visible from the following cycle.
    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so every swap reads pre-edge values.
        if (rst) begin
            w_bank         <= 2'd0;
            r_bank         <= 2'd1;
            d_bank         <= 2'd2;
            rdy_valid      <= 1'b0;
            stream_ready_q <= 1'b0;
        end else begin
            unique case ({bus.wr_frame_done, bus.rd_frame_next})
                2'b10: begin
                    w_bank         <= r_bank;
                    r_bank         <= w_bank;
                    rdy_valid      <= 1'b1;
                    stream_ready_q <= 1'b1;
                end
                2'b01: begin
                    if (rdy_valid) begin
                        d_bank    <= r_bank;
                        r_bank    <= d_bank;
                        rdy_valid <= 1'b0;
                    end
                end
                2'b11: begin
                    // Finished frame goes straight to display; R keeps its pending state.
                    d_bank         <= w_bank;
                    w_bank         <= d_bank;
                    stream_ready_q <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    // Sticky offset error and one-cycle read-data valid.
    always_ff @(posedge clk) begin
        if (rst) begin
            ofs_err_q  <= 1'b0;
            rd_valid_q <= 1'b0;
        end else begin
            if (err_hit) ofs_err_q <= 1'b1;
            rd_valid_q <= gnt;
        end
    end

`ifdef FB_STATS_EN
    // Saturating counters for overwritten (dropped) and repeated frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_cnt   <= '0;
            repeat_cnt <= '0;
        end else begin
            if (bus.wr_frame_done && !bus.rd_frame_next && rdy_valid && drop_cnt != 16'hFFFF)
                drop_cnt <= drop_cnt + 16'd1;
            if (bus.rd_frame_next && !bus.wr_frame_done && !rdy_valid && repeat_cnt != 16'hFFFF)
                repeat_cnt <= repeat_cnt + 16'd1;
        end
    end
`endif

    assign bus.ram_addr     = addr;
    assign bus.ram_we       = we;
    assign bus.ram_wdata    = bus.wr_data;
    assign bus.rd_gnt       = gnt;
    assign bus.rd_valid     = rd_valid_q;
    assign bus.rd_data      = RAM_DATA_WIDTH'(bus.ram_rdata);
    assign bus.stream_ready = stream_ready_q;
    assign bus.ofs_err      = ofs_err_q;

endmodule

// File: tb/tb_frame_bank_arbiter.sv
// Directed bench for frame_bank_arbiter: port decode, bank rotation, reset, offset errors.
module tb_frame_bank_arbiter;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    frame_bank_arbiter_if bus ();

`ifdef FB_STATS_EN
    logic [15:0] drop_cnt;
    logic [15:0] repeat_cnt;
`endif

    frame_bank_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus)
`ifdef FB_STATS_EN
        ,
        .drop_cnt   (drop_cnt),
        .repeat_cnt (repeat_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.wr_req        = 1'b0;
        bus.wr_ofs        = '0;
        bus.wr_frame_done = 1'b0;
        bus.rd_req        = 1'b0;
        bus.rd_ofs        = '0;
        bus.rd_frame_next = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b1;
        idle();
        bus.wr_data   = 16'hABCD;
        bus.ram_rdata = 16'h0000;
        tick();
        tick();

        // Requests during reset are blocked
        bus.wr_req = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_ofs = 12'd1;
        #1;
        check("rst_we", bus.ram_we, 0);
        check("rst_gnt", bus.rd_gnt, 0);
        check("rst_ready", bus.stream_ready, 0);
        check("rst_err", bus.ofs_err, 0);
        check("rst_rvalid", bus.rd_valid, 0);
        idle();
        tick();
        rst = 1'b0;

        // W=0 R=1 D=2: first write lands in bank 0
        bus.wr_req = 1'b1;
        bus.wr_ofs = 12'd5;
        #1;
        check("wr5_addr", bus.ram_addr, 5);
        check("wr5_we", bus.ram_we, 1);
        check("wr5_wdata", bus.ram_wdata, 16'hABCD);
        check("wr5_ready", bus.stream_ready, 0);
        tick();

        // Access in the frame_done cycle still uses W=0
        bus.wr_frame_done = 1'b1;
        bus.wr_ofs = 12'd7;
        #1;
        check("done_cycle_addr", bus.ram_addr, 7);
        tick();
        bus.wr_frame_done = 1'b0;
        bus.wr_ofs = 12'd0;
        #1;
        check("post_done_addr", bus.ram_addr, 3840);
        check("post_done_ready", bus.stream_ready, 1);
        tick();

        // W=1 R=0 D=2 rdy=1: read in the frame_next cycle uses D=2
        idle();
        bus.rd_frame_next = 1'b1;
        bus.rd_req = 1'b1;
        bus.rd_ofs = 12'd2;
        #1;
        check("next_cycle_addr", bus.ram_addr, 7682);
        check("next_cycle_gnt", bus.rd_gnt, 1);
        check("next_cycle_we", bus.ram_we, 0);
        tick();

        // W=1 R=2 D=0 rdy=0
        bus.rd_frame_next = 1'b0;
        bus.ram_rdata = 16'h1234;
        #1;
        check("rvalid_1", bus.rd_valid, 1);
        check("rdata_1", bus.rd_data, 16'h1234);
        check("rd2_addr", bus.ram_addr, 2);
        check("rd2_gnt", bus.rd_gnt, 1);
        tick();
        bus.rd_req = 1'b0;
        bus.ram_rdata = 16'h5678;
        #1;
        check("rvalid_2", bus.rd_valid, 1);
        check("rdata_2", bus.rd_data, 16'h5678);
        check("idle_addr", bus.ram_addr, 0);
        check("idle_we", bus.ram_we, 0);
        tick();

        // Writer beats reader
        bus.wr_req = 1'b1;
        bus.wr_ofs = 12'd10;
        bus.rd_req = 1'b1;
        bus.rd_ofs = 12'd3;
        #1;
        check("prio_we", bus.ram_we, 1);
        check("prio_gnt", bus.rd_gnt, 0);
        check("prio_addr", bus.ram_addr, 3850);
        tick();
        idle();
        #1;
        check("prio_rvalid", bus.rd_valid, 0);

        // frame_next without a ready frame repeats D=0
        bus.rd_frame_next = 1'b1;
        tick();
        bus.rd_frame_next = 1'b0;
        bus.rd_req = 1'b1;
        bus.rd_ofs = 12'd4;
        #1;
        check("repeat_addr", bus.ram_addr, 4);
        tick();

        // Reset with a read in flight
        idle();
        rst = 1'b1;
        #1;
        check("inflight_rvalid", bus.rd_valid, 1);
        tick();
        bus.wr_req = 1'b1;
        #1;
        check("rst_drop_rvalid", bus.rd_valid, 0);
        check("rst_mid_we", bus.ram_we, 0);
        tick();
        rst = 1'b0;
        bus.wr_ofs = 12'd0;
        #1;
        check("rst_mid_addr", bus.ram_addr, 0);
        check("rst_mid_we1", bus.ram_we, 1);
        check("rst_mid_ready", bus.stream_ready, 0);

        // Both events together from reset: D=0, W=2, R=1, rdy=0
        bus.wr_req = 1'b0;
        bus.wr_frame_done = 1'b1;
        bus.rd_frame_next = 1'b1;
        tick();
        idle();
        bus.wr_req = 1'b1;
        #1;
        check("both_w_addr", bus.ram_addr, 7680);
        check("both_ready", bus.stream_ready, 1);
        bus.wr_req = 1'b0;
        bus.rd_req = 1'b1;
        #1;
        check("both_d_addr", bus.ram_addr, 0);
        check("both_gnt", bus.rd_gnt, 1);
        bus.rd_req = 1'b0;
        bus.rd_frame_next = 1'b1;
        tick();
        bus.rd_frame_next = 1'b0;
        bus.rd_req = 1'b1;
        bus.rd_ofs = 12'd1;
        #1;
        check("both_norv_addr", bus.ram_addr, 1);
        bus.rd_req = 1'b0;
        bus.wr_frame_done = 1'b1;
        tick();
        bus.wr_frame_done = 1'b0;
        bus.wr_req = 1'b1;
        bus.wr_ofs = 12'd0;
        #1;
        check("both_r_was1_addr", bus.ram_addr, 3840);
        bus.wr_req = 1'b0;
        bus.rd_frame_next = 1'b1;
        tick();
        bus.rd_frame_next = 1'b0;
        bus.rd_req = 1'b1;
        bus.rd_ofs = 12'd0;
        #1;
        check("both_d2_addr", bus.ram_addr, 7680);

        // Offset boundaries, W=1
        bus.rd_req = 1'b0;
        bus.wr_req = 1'b1;
        bus.wr_ofs = 12'd3839;
        #1;
        check("last_ofs_addr", bus.ram_addr, 7679);
        check("last_ofs_we", bus.ram_we, 1);
        tick();
        check("last_ofs_err", bus.ofs_err, 0);
        bus.wr_ofs = 12'd3840;
        bus.rd_req = 1'b1;
        bus.rd_ofs = 12'd0;
        #1;
        check("bad_wr_we", bus.ram_we, 0);
        check("bad_wr_gnt", bus.rd_gnt, 0);
        check("bad_wr_addr", bus.ram_addr, 0);
        tick();
        idle();
        #1;
        check("bad_wr_err", bus.ofs_err, 1);
        bus.rd_req = 1'b1;
        bus.rd_ofs = 12'd4000;
        #1;
        check("bad_rd_gnt", bus.rd_gnt, 0);
        tick();
        idle();
        tick();
        check("err_sticky", bus.ofs_err, 1);

`ifdef FB_STATS_EN
        rst = 1'b1;
        tick();
        rst = 1'b0;
        #1;
        check("stats_rst_drop", drop_cnt, 0);
        check("stats_rst_repeat", repeat_cnt, 0);
        bus.wr_frame_done = 1'b1;
        tick();
        tick();
        bus.wr_frame_done = 1'b0;
        #1;
        check("drop_cnt", drop_cnt, 1);
        bus.rd_frame_next = 1'b1;
        tick();
        tick();
        bus.rd_frame_next = 1'b0;
        #1;
        check("repeat_cnt", repeat_cnt, 1);
        check("drop_cnt_hold", drop_cnt, 1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
